// File: rtl/softmax_pkg.sv
// Shared types and helpers for the softmax front-end.
// Scores are signed S9Q10.
package softmax_pkg;

    localparam int SCORE_W    = 20;
    localparam int SCORE_FRAC = 10;

    localparam logic signed [SCORE_W-1:0] S9Q10_MIN = -20'sd524288;

    typedef enum logic {
        LOAD,
        EMIT
    } state_t;

    // a - b at SCORE_W+1 bits, clamped back into SCORE_W
    function automatic logic signed [SCORE_W-1:0] sat_sub(
        input logic signed [SCORE_W-1:0] a,
        input logic signed [SCORE_W-1:0] b
    );
        logic signed [SCORE_W:0] d;
        d = {a[SCORE_W-1], a} - {b[SCORE_W-1], b};
        if (d[SCORE_W] != d[SCORE_W-1])
            sat_sub = d[SCORE_W] ? S9Q10_MIN : ~S9Q10_MIN;
        else
            sat_sub = d[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/softmax_row_buf.sv
// Row buffer: one write port, one synchronous read port.
// No reset on the array so it maps onto block RAM.
module softmax_row_buf #(
    parameter int DATA_W  = 20,
    parameter int MAX_LEN = 64,
    parameter int ADDR_W  = $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [MAX_LEN];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/softmax_row_max_sub.sv
// Softmax front-end: buffers one row, finds its max, then
// streams saturated (x - max) to the exp stage.
module softmax_row_max_sub
    import softmax_pkg::*;
#(
    parameter int  DATA_W  = 20,
    parameter int  MAX_LEN = 64,
    localparam int ADDR_W  = $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [ADDR_W:0]   m_row_len,
    output logic              ovf_err
);

    state_t state_q, state_d;

    logic [ADDR_W-1:0]        wr_cnt;
    logic [ADDR_W:0]          rd_cnt;
    logic [ADDR_W:0]          row_len;
    logic signed [DATA_W-1:0] max_q;

    logic        accept, full, row_end;
    logic        pop, issue, out_free;
    logic [1:0]  occ;

    logic [DATA_W-1:0]        ram_q;
    logic signed [DATA_W-1:0] rd_data;
    logic                     rd_v, rd_last;
    logic [DATA_W-1:0]        skid_data;
    logic                     skid_v, skid_last;

    assign s_ready   = rst_n && (state_q == LOAD);
    assign m_row_len = row_len;
    assign full      = (wr_cnt == ADDR_W'(MAX_LEN - 1));
    assign pop       = m_valid & m_ready;
    assign out_free  = ~m_valid | m_ready;
    assign rd_data   = sat_sub(ram_q, max_q);

    // Items already committed downstream of the read issue point
    assign occ = {1'b0, rd_v} + {1'b0, m_valid}
               + {1'b0, skid_v} - {1'b0, pop};

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        row_end = 1'b0;
        issue   = 1'b0;
        unique case (state_q)
            LOAD: begin
                accept  = s_valid & s_ready;
                row_end = accept & (s_last | full);
                if (row_end)
                    state_d = EMIT;
            end
            EMIT: begin
                issue = (rd_cnt != row_len) && (occ < 2'd2);
                if (pop && m_last)
                    state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    softmax_row_buf #(
        .DATA_W  (DATA_W),
        .MAX_LEN (MAX_LEN),
        .ADDR_W  (ADDR_W)
    ) u_buf (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_cnt),
        .wdata (s_data),
        .re    (issue),
        .raddr (rd_cnt[ADDR_W-1:0]),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            row_len <= '0;
            max_q   <= '0;
            ovf_err <= 1'b0;
            rd_v    <= 1'b0;
            rd_last <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_err <= accept & full & ~s_last;
            if (accept) begin
                if (wr_cnt == '0 || $signed(s_data) > max_q)
                    max_q <= s_data;
                wr_cnt <= row_end ? '0 : wr_cnt + 1'b1;
            end
            if (row_end)
                row_len <= {1'b0, wr_cnt} + 1'b1;
            if (pop && m_last)
                rd_cnt <= '0;
            else if (issue)
                rd_cnt <= rd_cnt + 1'b1;
            rd_v    <= issue;
            rd_last <= issue && (rd_cnt == row_len - 1'b1);
        end
    end

    // Read stage never stalls; the skid absorbs it when output is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_last    <= 1'b0;
            skid_v    <= 1'b0;
            skid_data <= '0;
            skid_last <= 1'b0;
        end else if (out_free) begin
            if (skid_v) begin
                m_valid   <= 1'b1;
                m_data    <= skid_data;
                m_last    <= skid_last;
                skid_v    <= rd_v;
                skid_data <= rd_data;
                skid_last <= rd_last;
            end else begin
                m_valid <= rd_v;
                m_data  <= rd_v ? rd_data : '0;
                m_last  <= rd_v & rd_last;
            end
        end else if (rd_v) begin
            skid_v    <= 1'b1;
            skid_data <= rd_data;
            skid_last <= rd_last;
        end
    end

endmodule
